sram_rw_port_ctrl: RTL and testbench

- Initiator-side controller for a single-port RW0 SRAM macro (4096 x 15, one-cycle registered-address read).
- Converts a valid/ready request stream (read or write) into RW0_en/RW0_wmode/RW0_addr/RW0_wdata.
- Captures RW0_rdata in the one cycle it is valid and returns it on a valid/ready response stream.
- Zero-fills the array after every reset, because macro contents are random at power-up.

---
 rtl/sram_rw_port_ctrl_pkg.sv | 14 +
 rtl/sram_rw_port_ctrl_if.sv | 27 ++
 rtl/sram_resp_fifo.sv | 61 ++++++
 rtl/sram_rw_port_ctrl.sv | 116 +++++++++++
 tb/tb_sram_rw_port_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sram_rw_port_ctrl_pkg.sv
// Shared widths, depth and controller state encoding for the RW0 SRAM port controller.
package sram_rw_port_ctrl_pkg;

    localparam int ADDR_W_DEF = 12;
    localparam int DATA_W_DEF = 15;
    localparam int DEPTH_DEF  = 1 << ADDR_W_DEF;

    typedef enum logic [1:0] {
        ST_WAKE = 2'd0,
        ST_INIT = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage

// File: rtl/sram_rw_port_ctrl_if.sv
// Request/response valid-ready streams between a client (master) and the SRAM port controller (slave).
interface sram_rw_port_ctrl_if
    import sram_rw_port_ctrl_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_rdata;

    modport master (
        output req_valid, req_write, req_addr, req_wdata, resp_ready,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata, resp_ready,
        output req_ready, resp_valid, resp_rdata
    );

endinterface

// File: rtl/sram_resp_fifo.sv
// Two-entry in-order response FIFO; head entry is registered straight onto pop_dat_o.
// Push-to-valid is one cycle; the caller guarantees no push while full (credit-limited upstream).
module sram_resp_fifo #(
    parameter int DATA_W = 15
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_dat_i,
    output logic              pop_vld_o,
    input  logic              pop_rdy_i,
    output logic [DATA_W-1:0] pop_dat_o,
    output logic [1:0]        count_o
);

    logic [1:0]        cnt_q;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;
    logic              pop;

    assign pop       = pop_rdy_i && (cnt_q != 2'd0);
    assign pop_vld_o = (cnt_q != 2'd0);
    assign pop_dat_o = head_q;
    assign count_o   = cnt_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= 2'd0;
            head_q <= '0;
            tail_q <= '0;
        end else begin
            case ({push_i, pop})
                2'b10: begin
                    if (cnt_q == 2'd0) begin
                        head_q <= push_dat_i;
                        cnt_q  <= 2'd1;
                    end else if (cnt_q == 2'd1) begin
                        tail_q <= push_dat_i;
                        cnt_q  <= 2'd2;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                    cnt_q  <= cnt_q - 2'd1;
                end
                2'b11: begin
                    // Occupancy is unchanged; with one entry the new word becomes the head.
                    if (cnt_q == 2'd1) begin
                        head_q <= push_dat_i;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= push_dat_i;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/sram_rw_port_ctrl.sv
// Drives a single-port RW0 SRAM from a read/write request stream and returns read data in order.
// Read accept to resp_valid is two cycles; reads are credit-limited to two outstanding, writes never stall in RUN.
module sram_rw_port_ctrl
    import sram_rw_port_ctrl_pkg::*;
#(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int DATA_W    = DATA_W_DEF,
    parameter bit INIT_ZERO = 1'b1
) (
    input  logic              clock,
    input  logic              reset_n,
    sram_rw_port_ctrl_if.slave bus,
    output logic              init_done,
    output logic              RW0_en,
    output logic              RW0_wmode,
    output logic [ADDR_W-1:0] RW0_addr,
    output logic [DATA_W-1:0] RW0_wdata,
    input  logic [DATA_W-1:0] RW0_rdata
);

    localparam logic [ADDR_W-1:0] CNT_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] CNT_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic              init_done_q;
    logic              inflight_q;
    logic              inflight_d;

    logic [1:0]        fifo_cnt;
    logic              pop;
    logic [2:0]        outstanding;
    logic [2:0]        limit;
    logic              rd_credit;
    logic              req_ready_w;

    // A read may issue only if it will still have a FIFO slot when its data lands.
    assign pop         = bus.resp_valid && bus.resp_ready;
    assign outstanding = {1'b0, fifo_cnt} + {2'b00, inflight_q};
    assign limit       = 3'd2 + {2'b00, pop};
    assign rd_credit   = outstanding < limit;
    assign req_ready_w = (state_q == ST_RUN) && (bus.req_write || rd_credit);

    assign bus.req_ready = req_ready_w;
    assign init_done     = init_done_q;
    assign inflight_d    = (state_q == ST_RUN) && RW0_en && !RW0_wmode;

    always_comb begin
        RW0_en    = 1'b0;
        RW0_wmode = bus.req_write;
        RW0_addr  = bus.req_addr;
        RW0_wdata = bus.req_wdata;
        case (state_q)
            ST_INIT: begin
                RW0_en    = 1'b1;
                RW0_wmode = 1'b1;
                RW0_addr  = cnt_q;
                RW0_wdata = '0;
            end
            ST_RUN: begin
                RW0_en = bus.req_valid && req_ready_w;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_WAKE;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            inflight_q  <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            case (state_q)
                ST_WAKE: begin
                    if (INIT_ZERO) begin
                        state_q <= ST_INIT;
                    end else begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_INIT: begin
                    cnt_q <= cnt_q + CNT_ONE;
                    if (cnt_q == CNT_LAST) begin
                        state_q     <= ST_RUN;
                        init_done_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    init_done_q <= 1'b1;
                end
                default: begin
                    state_q <= ST_WAKE;
                end
            endcase
        end
    end

    // Read data is only valid the cycle after issue, so the in-flight flag is the push strobe.
    sram_resp_fifo #(
        .DATA_W (DATA_W)
    ) u_resp_fifo (
        .clock      (clock),
        .reset_n    (reset_n),
        .push_i     (inflight_q),
        .push_dat_i (RW0_rdata),
        .pop_vld_o  (bus.resp_valid),
        .pop_rdy_i  (bus.resp_ready),
        .pop_dat_o  (bus.resp_rdata),
        .count_o    (fifo_cnt)
    );

endmodule

// File: tb/tb_sram_rw_port_ctrl.sv
// Directed bench for sram_rw_port_ctrl with a behavioural RW0 macro model (registered-address read).
module tb_sram_rw_port_ctrl;
    import sram_rw_port_ctrl_pkg::*;

    localparam int AW    = ADDR_W_DEF;
    localparam int DW    = DATA_W_DEF;
    localparam int DEPTH = DEPTH_DEF;

    logic          clock;
    logic          reset_n;
    logic          init_done;
    logic          RW0_en;
    logic          RW0_wmode;
    logic [AW-1:0] RW0_addr;
    logic [DW-1:0] RW0_wdata;
    logic [DW-1:0] RW0_rdata;

    sram_rw_port_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    sram_rw_port_ctrl #(
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .INIT_ZERO (1'b1)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .bus       (bus),
        .init_done (init_done),
        .RW0_en    (RW0_en),
        .RW0_wmode (RW0_wmode),
        .RW0_addr  (RW0_addr),
        .RW0_wdata (RW0_wdata),
        .RW0_rdata (RW0_rdata)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Macro model: random power-up contents, random rdata outside read-response cycles.
    logic [DW-1:0] mem [DEPTH];
    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom) | DW'(1);
        RW0_rdata = '0;
    end
    always @(posedge clock) begin
        if (RW0_en && RW0_wmode) begin
            mem[RW0_addr] <= RW0_wdata;
            RW0_rdata     <= DW'($urandom);
        end else if (RW0_en) begin
            RW0_rdata <= mem[RW0_addr];
        end else begin
            RW0_rdata <= DW'($urandom);
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic rr);
        @(negedge clock);
        bus.req_valid  = v;
        bus.req_write  = w;
        bus.req_addr   = a;
        bus.req_wdata  = d;
        bus.resp_ready = rr;
        #1;
    endtask

    // Entered at the negedge where reset_n was just released.
    task automatic sweep_check(input string tag);
        int bad   = 0;
        int stale = 0;
        #1;
        chk({tag, "_wake_en"}, 32'(RW0_en), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clock);
            #1;
            if (!(RW0_en === 1'b1 && RW0_wmode === 1'b1 && RW0_addr === AW'(i) &&
                  RW0_wdata === '0 && bus.req_ready === 1'b0 && init_done === 1'b0)) bad++;
            if (bus.resp_valid !== 1'b0) stale++;
        end
        chk({tag, "_bad_cycles"}, 32'(bad), 32'd0);
        chk({tag, "_stale_resp"}, 32'(stale), 32'd0);
        @(negedge clock);
        #1;
        chk({tag, "_en_after"}, 32'(RW0_en), 32'd0);
        chk({tag, "_init_done"}, 32'(init_done), 32'd1);
    endtask

    typedef struct {
        logic          v;
        logic          w;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
        logic          rr;
        logic          x_rdy;
        logic          x_en;
        logic          x_rv;
        logic [DW-1:0] x_dat;
    } vec_t;

    vec_t tbl [13];

    initial begin
        int            acc;
        logic [AW-1:0] ra;
        int            rdy_bad;
        int            cyc_bad;
        logic [DW-1:0] got [$];
        int            gcyc [$];

        // One row per cycle: request, resp_ready | expected req_ready, RW0_en, resp_valid, resp_rdata.
        tbl[0]  = '{1'b1, 1'b0, 12'h7A3, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0000};
        tbl[1]  = '{1'b1, 1'b1, 12'h010, 15'h5A5A, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0000};
        tbl[2]  = '{1'b1, 1'b0, 12'h010, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 15'h0000};
        tbl[3]  = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000};
        tbl[4]  = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 15'h5A5A};
        tbl[5]  = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000};
        tbl[6]  = '{1'b1, 1'b1, 12'h030, 15'h1111, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0000};
        tbl[7]  = '{1'b1, 1'b0, 12'h030, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0000};
        tbl[8]  = '{1'b1, 1'b1, 12'h030, 15'h2222, 1'b1, 1'b1, 1'b1, 1'b0, 15'h0000};
        tbl[9]  = '{1'b1, 1'b0, 12'h030, 15'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 15'h1111};
        tbl[10] = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000};
        tbl[11] = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 15'h2222};
        tbl[12] = '{1'b0, 1'b0, 12'h000, 15'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 15'h0000};

        reset_n        = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b0;

        repeat (3) @(negedge clock);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", 32'(bus.resp_rdata), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        chk("rst_en", 32'(RW0_en), 32'd0);

        @(negedge clock);
        reset_n = 1'b1;
        sweep_check("sweep1");

        foreach (tbl[i]) begin
            drive(tbl[i].v, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].rr);
            chk($sformatf("vec%0d_req_ready", i), 32'(bus.req_ready), 32'(tbl[i].x_rdy));
            chk($sformatf("vec%0d_en", i), 32'(RW0_en), 32'(tbl[i].x_en));
            chk($sformatf("vec%0d_resp_valid", i), 32'(bus.resp_valid), 32'(tbl[i].x_rv));
            if (tbl[i].x_rv) chk($sformatf("vec%0d_rdata", i), 32'(bus.resp_rdata), 32'(tbl[i].x_dat));
            if (tbl[i].x_en) begin
                chk($sformatf("vec%0d_addr", i), 32'(RW0_addr), 32'(tbl[i].a));
                chk($sformatf("vec%0d_wmode", i), 32'(RW0_wmode), 32'(tbl[i].w));
            end
        end

        // Fill 0..15 with data=addr, then stream 16 reads back to back.
        rdy_bad = 0;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, AW'(i), DW'(i), 1'b1);
            if (bus.req_ready !== 1'b1) rdy_bad++;
        end
        for (int k = 0; k < 20; k++) begin
            if (k < 16) drive(1'b1, 1'b0, AW'(k), '0, 1'b1);
            else        drive(1'b0, 1'b0, '0, '0, 1'b1);
            if (k < 16 && bus.req_ready !== 1'b1) rdy_bad++;
            if (bus.resp_valid === 1'b1) begin
                got.push_back(bus.resp_rdata);
                gcyc.push_back(k);
            end
        end
        chk("burst_req_ready_drops", 32'(rdy_bad), 32'd0);
        chk("burst_resp_count", 32'(got.size()), 32'd16);
        cyc_bad = 0;
        foreach (got[j]) begin
            chk($sformatf("burst_rdata%0d", j), 32'(got[j]), 32'(j));
            if (gcyc[j] != j + 2) cyc_bad++;
        end
        chk("burst_resp_timing", 32'(cyc_bad), 32'd0);

        // Stall: resp_ready low, continuous reads of 5,6,7...
        acc = 0;
        ra  = AW'(5);
        for (int k = 0; k < 6; k++) begin
            drive(1'b1, 1'b0, ra, '0, 1'b0);
            if (bus.req_ready === 1'b1) begin
                acc++;
                ra = ra + AW'(1);
            end
        end
        chk("stall_accepts", 32'(acc), 32'd2);
        chk("stall_read_rdy", 32'(bus.req_ready), 32'd0);
        drive(1'b1, 1'b1, 12'h020, 15'h0ABC, 1'b0);
        chk("stall_write_rdy", 32'(bus.req_ready), 32'd1);
        chk("stall_write_en", 32'(RW0_en), 32'd1);
        chk("stall_head_vld", 32'(bus.resp_valid), 32'd1);
        chk("stall_head_dat", 32'(bus.resp_rdata), 32'd5);
        drive(1'b1, 1'b0, ra, '0, 1'b1);
        chk("resume_rdy", 32'(bus.req_ready), 32'd1);
        chk("drain0_dat", 32'(bus.resp_rdata), 32'd5);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain1_vld", 32'(bus.resp_valid), 32'd1);
        chk("drain1_dat", 32'(bus.resp_rdata), 32'd6);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain2_vld", 32'(bus.resp_valid), 32'd1);
        chk("drain2_dat", 32'(bus.resp_rdata), 32'd7);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("drain_empty", 32'(bus.resp_valid), 32'd0);
        drive(1'b1, 1'b0, 12'h020, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("stall_write_vld", 32'(bus.resp_valid), 32'd1);
        chk("stall_write_dat", 32'(bus.resp_rdata), 32'h0ABC);

        // Reset with one read buffered and one in flight.
        drive(1'b1, 1'b0, 12'h003, '0, 1'b0);
        drive(1'b1, 1'b0, 12'h004, '0, 1'b0);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        chk("prerst_vld", 32'(bus.resp_valid), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_vld", 32'(bus.resp_valid), 32'd0);
        chk("midrst_rdata", 32'(bus.resp_rdata), 32'd0);
        chk("midrst_rdy", 32'(bus.req_ready), 32'd0);
        chk("midrst_en", 32'(RW0_en), 32'd0);
        chk("midrst_init_done", 32'(init_done), 32'd0);
        repeat (2) @(negedge clock);
        bus.resp_ready = 1'b1;
        reset_n        = 1'b1;
        sweep_check("sweep2");
        drive(1'b1, 1'b0, 12'h005, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        chk("rezero_vld", 32'(bus.resp_valid), 32'd1);
        chk("rezero_dat", 32'(bus.resp_rdata), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached before end of test");
        $fatal(1);
    end

endmodule
